// File: rtl/uart_control_tx.sv
// uart_control_tx
//   Transmit side of the UART control-frame link. On a send request it latches
//   the link configuration and shifts out the 6-byte frame
//     AA 55 CTRL_HI CTRL_LO CHECKSUM 55
//   LSB first, with one start bit and an idle-high stop/gap period per byte.
//   Bit timing comes from a 16x-baud enable tick supplied by the divider.
//
//   Optional feature macro: UART_CTRL_TX_PARITY_EN
//     defined     -> an even-parity bit follows the 8 data bits of every byte
//     not defined -> data bits go straight to the stop period
//
// Ports
//   clock        in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   bps_tick     in   1-cycle enable at 16x baud
//   send         in   frame request, only looked at while idle
//   baudrate     in   [3:0] baud code      -> control[11:8]
//   data_width   in   [1:0] width code     -> control[5:4]
//   stop         in   [1:0] stop code      -> control[3:2]
//   parity_check in   [1:0] parity code    -> control[1:0]
//   tx           out  serial line, idle high
//   busy         out  frame in progress
//   done         out  1-cycle pulse at the end of the last stop period
module uart_control_tx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_TICKS = 32
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       bps_tick,
  input  logic       send,
  input  logic [3:0] baudrate,
  input  logic [1:0] data_width,
  input  logic [1:0] stop,
  input  logic [1:0] parity_check,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned TW = $clog2(STOP_TICKS + 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state_r;
  logic [TW-1:0]   tick_cnt_r;
  logic [2:0]      bit_cnt_r;
  logic [2:0]      byte_idx_r;
  logic [7:0]      ctrl_hi_r;
  logic [7:0]      ctrl_lo_r;
  logic            tx_r;
  logic            busy_r;
  logic            done_r;

  logic [7:0]      cur_byte_s;
  logic [2:0]      next_bit_s;
  logic            bit_end_s;
  logic            stop_end_s;

`ifdef UART_CTRL_TX_PARITY_EN
  // Even parity: the extra bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  // Select the byte currently on the wire from the latched control word.
  always_comb begin
    cur_byte_s = 8'hFF;
    case (byte_idx_r)
      3'd0:    cur_byte_s = 8'hAA;
      3'd1:    cur_byte_s = 8'h55;
      3'd2:    cur_byte_s = ctrl_hi_r;
      3'd3:    cur_byte_s = ctrl_lo_r;
      3'd4:    cur_byte_s = ctrl_hi_r + ctrl_lo_r;  // checksum wraps mod 256
      3'd5:    cur_byte_s = 8'h55;
      default: cur_byte_s = 8'hFF;
    endcase
  end

  // Tick-count end conditions and the index of the data bit that goes out next.
  always_comb begin
    next_bit_s = bit_cnt_r + 3'd1;
    bit_end_s  = bps_tick && (tick_cnt_r == BIT_LAST);
    stop_end_s = bps_tick && (tick_cnt_r == STOP_LAST);
  end

  // Frame sequencer: state, counters, latched config and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      tick_cnt_r <= '0;
      bit_cnt_r  <= 3'd0;
      byte_idx_r <= 3'd0;
      ctrl_hi_r  <= 8'h00;
      ctrl_lo_r  <= 8'h00;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      // Counter advances on every tick; each end-of-period branch clears it.
      if (bps_tick) begin
        tick_cnt_r <= tick_cnt_r + {{(TW-1){1'b0}}, 1'b1};
      end
      case (state_r)
        IDLE: begin
          tx_r       <= 1'b1;
          busy_r     <= 1'b0;
          tick_cnt_r <= '0;
          if (send) begin
            ctrl_hi_r  <= {4'b0000, baudrate};
            ctrl_lo_r  <= {2'b00, data_width, stop, parity_check};
            byte_idx_r <= 3'd0;
            bit_cnt_r  <= 3'd0;
            busy_r     <= 1'b1;
            tx_r       <= 1'b0;
            state_r    <= START;
          end
        end
        START: begin
          if (bit_end_s) begin
            tick_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            tx_r       <= cur_byte_s[0];
            state_r    <= DATA;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            tick_cnt_r <= '0;
            if (bit_cnt_r == 3'd7) begin
`ifdef UART_CTRL_TX_PARITY_EN
              tx_r    <= even_parity(cur_byte_s);
              state_r <= PARITY;
`else
              tx_r    <= 1'b1;
              state_r <= STOP;
`endif
            end else begin
              bit_cnt_r <= next_bit_s;
              tx_r      <= cur_byte_s[next_bit_s];
            end
          end
        end
`ifdef UART_CTRL_TX_PARITY_EN
        PARITY: begin
          if (bit_end_s) begin
            tick_cnt_r <= '0;
            tx_r       <= 1'b1;
            state_r    <= STOP;
          end
        end
`endif
        STOP: begin
          if (stop_end_s) begin
            tick_cnt_r <= '0;
            if (byte_idx_r == 3'd5) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              tx_r    <= 1'b1;
              state_r <= IDLE;
            end else begin
              byte_idx_r <= byte_idx_r + 3'd1;
              tx_r       <= 1'b0;
              state_r    <= START;
            end
          end
        end
        default: begin
          tick_cnt_r <= '0;
          busy_r     <= 1'b0;
          tx_r       <= 1'b1;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign tx   = tx_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_uart_control_tx.sv
// Directed bench for uart_control_tx. The bench owns the 16x tick (one tick
// every 4 clocks) and decodes the serial line by counting ticks from the
// accepting clock edge, sampling each bit mid-period.
module tb_uart_control_tx;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       bps_tick;
  logic       send;
  logic [3:0] baudrate;
  logic [1:0] data_width;
  logic [1:0] stop;
  logic [1:0] parity_check;
  logic       tx;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  int tick_total = 0;

`ifdef UART_CTRL_TX_PARITY_EN
  localparam int FRAME_TICKS = 1152;
`else
  localparam int FRAME_TICKS = 1056;
`endif

  // Expected frames, byte 0 in bits [7:0].
  localparam logic [47:0] FRAME_A = {8'h55, 8'h36, 8'h30, 8'h06, 8'h55, 8'hAA};
  localparam logic [47:0] FRAME_B = {8'h55, 8'h4E, 8'h3F, 8'h0F, 8'h55, 8'hAA};
  localparam logic [47:0] FRAME_C = {8'h55, 8'h02, 8'h01, 8'h01, 8'h55, 8'hAA};

  uart_control_tx dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bps_tick     (bps_tick),
    .send         (send),
    .baudrate     (baudrate),
    .data_width   (data_width),
    .stop         (stop),
    .parity_check (parity_check),
    .tx           (tx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  // Tick generator: one-cycle pulse every fourth clock, changed on negedge.
  initial begin
    logic [1:0] div;
    div = 2'd0;
    bps_tick = 1'b0;
    forever begin
      @(negedge clock);
      div = div + 2'd1;
      bps_tick = (div == 2'd3);
    end
  end

  // Running count of tick edges, used for frame-length checks.
  always @(posedge clock) if (bps_tick) tick_total <= tick_total + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Wait n tick edges, return at the following negedge.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      while (!bps_tick) @(posedge clock);
    end
    @(negedge clock);
  endtask

  // Drive config and a send request; returns at the negedge after acceptance.
  task automatic start_frame(input logic [3:0] b, input logic [1:0] w, input logic [1:0] s,
                             input logic [1:0] p, input bit hold);
    baudrate = b; data_width = w; stop = s; parity_check = p;
    send = 1'b1;
    @(negedge clock);
    check_val("accept_busy", {31'd0, busy}, 32'd1);
    check_val("accept_tx", {31'd0, tx}, 32'd0);
    if (!hold) send = 1'b0;
  endtask

  // Decode one frame starting at the negedge after its accepting edge.
  task automatic recv_frame(input logic [47:0] exp, input logic [5:0] exp_par, input bit restart);
    int t0;
    logic [7:0] got;
    logic st, sp, seen;
    t0 = tick_total;
    wait_ticks(8);
    for (int b = 0; b < 6; b++) begin
      st = tx;
      for (int k = 0; k < 8; k++) begin
        wait_ticks(16);
        got[k] = tx;
      end
`ifdef UART_CTRL_TX_PARITY_EN
      wait_ticks(16);
      check_val($sformatf("parity%0d", b), {31'd0, tx}, {31'd0, exp_par[b]});
`endif
      wait_ticks(16);
      sp = tx;
      check_val($sformatf("framing%0d", b), {30'd0, st, sp}, 32'd1);
      check_val($sformatf("byte%0d", b), {24'd0, got}, {24'd0, exp[8*b +: 8]});
      if (b < 5) wait_ticks(32);
    end
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      if (done) seen = 1'b1;
      else @(negedge clock);
    end
    check_val("done_seen", {31'd0, seen}, 32'd1);
    check_val("frame_ticks", tick_total - t0, FRAME_TICKS);
    check_val("done_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    if (restart) begin
      check_val("restart_tx", {31'd0, tx}, 32'd0);
      check_val("restart_busy", {31'd0, busy}, 32'd1);
    end else begin
      check_val("done_clear", {30'd0, done, busy}, 32'd0);
      check_val("idle_tx", {31'd0, tx}, 32'd1);
    end
  endtask

  initial begin
    logic seen;
    reset_n = 1'b0;
    send = 1'b1;
    baudrate = 4'd6; data_width = 2'd3; stop = 2'd0; parity_check = 2'd0;
    repeat (2) @(negedge clock);
    check_val("reset_outs", {29'd0, tx, busy, done}, 32'd4);
    reset_n = 1'b1;
    send = 1'b0;
    @(negedge clock);
    check_val("post_reset_idle", {30'd0, tx, busy}, 32'd2);

    // Frame A: baud 6, width 3.
    start_frame(4'd6, 2'd3, 2'd0, 2'd0, 1'b0);
    recv_frame(FRAME_A, 6'b000000, 1'b0);

    // Frame C: odd-weight bytes 2..4.
    start_frame(4'd1, 2'd0, 2'd0, 2'd1, 1'b0);
    recv_frame(FRAME_C, 6'b011100, 1'b0);

    // Frame B with send pulses and config changes while busy.
    start_frame(4'd15, 2'd3, 2'd3, 2'd3, 1'b0);
    fork
      recv_frame(FRAME_B, 6'b000000, 1'b0);
      begin
        repeat (20) @(negedge clock);
        send = 1'b1; baudrate = 4'd0; data_width = 2'd0; stop = 2'd1; parity_check = 2'd2;
        repeat (3) @(negedge clock);
        send = 1'b0;
        repeat (300) @(negedge clock);
        send = 1'b1; baudrate = 4'd9;
        @(negedge clock);
        send = 1'b0;
      end
    join

    // Reset in the middle of byte 2 (0x06, bit 0 = 0).
    start_frame(4'd6, 2'd3, 2'd0, 2'd0, 1'b0);
    wait_ticks(376);
    check_val("pre_reset_tx", {31'd0, tx}, 32'd0);
    reset_n = 1'b0;
    @(negedge clock);
    check_val("mid_reset_outs", {29'd0, tx, busy, done}, 32'd4);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clock);
      if (done || busy) seen = 1'b1;
    end
    check_val("no_done_after_reset", {31'd0, seen}, 32'd0);
    start_frame(4'd6, 2'd3, 2'd0, 2'd0, 1'b0);
    recv_frame(FRAME_A, 6'b000000, 1'b0);

    // send held high: second frame starts one cycle after done.
    start_frame(4'd6, 2'd3, 2'd0, 2'd0, 1'b1);
    recv_frame(FRAME_A, 6'b000000, 1'b1);
    send = 1'b0;
    recv_frame(FRAME_A, 6'b000000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
